// File: rtl/vdp_cpu_bus_bridge.sv
// Host-to-VDP bus bridge: filters async host strobes, queues writes in a FIFO and
// sequences the VDP REQ/ACK handshake, servicing reads in order behind queued writes.
module vdp_cpu_bus_bridge #(
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned BIT_REVERSE = 1
) (
  input  logic                          clk_w,
  input  logic                          rst_n_w,
  input  logic                          csr_n,
  input  logic                          csw_n,
  input  logic [ADDR_W-1:0]             mode,
  input  logic [7:0]                    cd_in,
  output logic                          vdp_req,
  output logic                          vdp_wrt,
  output logic [15:0]                   vdp_adr,
  output logic [7:0]                    vdp_dbo,
  input  logic                          vdp_ack,
  input  logic [7:0]                    vdp_dbi,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic                          cpu_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned ENT_W = ADDR_W + 8;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  // Strobe index 0 = csr_n, 1 = csw_n
  logic [1:0]                  raw_c;
  logic [1:0][SYNC_STAGES-1:0] sync_q;
  logic [1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]                  filt_q, filt_d;

  logic [ADDR_W-1:0] mode_q;
  logic [7:0]        cd_q, wr_data_c;

  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [ENT_W-1:0]  head_c;
  logic              full_c, empty_c, push_c, pop_c;

  logic              wr_ev_c, rd_ev_c, csr_rise_c, rd_accept_c, rd_done_c;
  logic              rd_pending_q;
  logic [ADDR_W-1:0] rd_port_q;

  state_t            state_q, state_d;
  logic              req_d, wrt_d;
  logic [15:0]       adr_d;
  logic [7:0]        dbo_d;

  assign raw_c = {csw_n, csr_n};

  // Synchroniser chains and debounce state
  always_ff @(posedge clk_w or negedge rst_n_w) begin
    if (!rst_n_w) begin
      sync_q <= '1;
      filt_q <= '1;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw_c[i]};
      end
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  // Filtered strobe flips after DEBOUNCE consecutive differing synchronised samples
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync_q[i][SYNC_STAGES-1] != filt_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE - 1)) begin
          filt_d[i] = sync_q[i][SYNC_STAGES-1];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Events fire on the edge where the filtered strobe falls, so the push lands in that same cycle
  assign rd_ev_c     = filt_q[0] & ~filt_d[0] & filt_d[1];
  assign wr_ev_c     = filt_q[1] & ~filt_d[1] & filt_d[0];
  assign csr_rise_c  = ~filt_q[0] & filt_d[0];
  assign rd_accept_c = rd_ev_c & ~rd_pending_q;

  always_ff @(posedge clk_w or negedge rst_n_w) begin
    if (!rst_n_w) begin
      mode_q <= '0;
      cd_q   <= '0;
    end else begin
      mode_q <= mode;
      cd_q   <= cd_in;
    end
  end

  always_comb begin
    wr_data_c = cd_q;
    if (BIT_REVERSE != 0) begin
      for (int i = 0; i < 8; i++) begin
        wr_data_c[i] = cd_q[7-i];
      end
    end
  end

  assign full_c  = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign empty_c = (fifo_level == '0);
  assign push_c  = wr_ev_c & ~full_c;
  assign head_c  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_w) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= {mode_q, wr_data_c};
    end
  end

  // Pointers wrap naturally since FIFO_DEPTH is a power of two
  always_ff @(posedge clk_w or negedge rst_n_w) begin
    if (!rst_n_w) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(push_c);
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop_c);
      case ({push_c, pop_c})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (wr_ev_c && full_c) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  // Host read bookkeeping; a read issued to the VDP always completes
  always_ff @(posedge clk_w or negedge rst_n_w) begin
    if (!rst_n_w) begin
      rd_pending_q <= 1'b0;
      rd_port_q    <= '0;
      cpu_ready    <= 1'b1;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
    end else begin
      if (rd_accept_c) begin
        rd_pending_q <= 1'b1;
        rd_port_q    <= mode_q;
        cpu_ready    <= 1'b0;
      end else if (rd_done_c) begin
        rd_pending_q <= 1'b0;
        cpu_ready    <= 1'b1;
      end
      if (rd_done_c) begin
        rd_data <= vdp_dbi;
      end
      if (rd_done_c && !filt_d[0]) begin
        rd_valid <= 1'b1;
      end else if (csr_rise_c || rd_accept_c) begin
        rd_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_w or negedge rst_n_w) begin
    if (!rst_n_w) begin
      state_q <= ST_IDLE;
      vdp_req <= 1'b0;
      vdp_wrt <= 1'b0;
      vdp_adr <= '0;
      vdp_dbo <= '0;
    end else begin
      state_q <= state_d;
      vdp_req <= req_d;
      vdp_wrt <= wrt_d;
      vdp_adr <= adr_d;
      vdp_dbo <= dbo_d;
    end
  end

  // Queued writes take priority over the pending read
  always_comb begin
    state_d   = state_q;
    req_d     = vdp_req;
    wrt_d     = vdp_wrt;
    adr_d     = vdp_adr;
    dbo_d     = vdp_dbo;
    pop_c     = 1'b0;
    rd_done_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_d = 1'b0;
        if (!empty_c) begin
          state_d = ST_ISSUE;
          wrt_d   = 1'b1;
          adr_d   = 16'(head_c[ENT_W-1:8]);
          dbo_d   = head_c[7:0];
        end else if (rd_pending_q) begin
          state_d = ST_ISSUE;
          wrt_d   = 1'b0;
          adr_d   = 16'(rd_port_q);
        end
      end
      ST_ISSUE: begin
        req_d   = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (vdp_ack) begin
          req_d     = 1'b0;
          state_d   = ST_IDLE;
          pop_c     = vdp_wrt;
          rd_done_c = ~vdp_wrt;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
